// File: rtl/dmac_pkg.sv
// Shared DMAC definitions: slave register map, slave FSM encoding and the
// 80-bit descriptor layout exchanged between the slave and the master.
package dmac_pkg;

    localparam logic [7:0] ADDR_START      = 8'h00;
    localparam logic [7:0] ADDR_INT_STATUS = 8'h01;
    localparam logic [7:0] ADDR_INT_ENABLE = 8'h02;
    localparam logic [7:0] ADDR_SRC        = 8'h03;
    localparam logic [7:0] ADDR_DEST       = 8'h04;
    localparam logic [7:0] ADDR_SIZE       = 8'h05;
    localparam logic [7:0] ADDR_FIFO_COUNT = 8'h06;
    localparam logic [7:0] ADDR_STATE      = 8'h07;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int DESC_W = 80;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dest;
        logic [15:0] size;
    } desc_t;

endpackage

// File: rtl/dmac_desc_fifo.sv
// Descriptor FIFO: power-of-two depth, head entry visible combinationally,
// a push into a full FIFO is accepted only when a pop happens on the same edge.
module dmac_desc_fifo
    import dmac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DESC_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic [DESC_W-1:0] head
);

    logic [DESC_W-1:0] mem_reg [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && wr_ptr_reg == PW'(gi)) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dmac_slave.sv
// DMAC slave: bus register file, descriptor queueing towards the DMAC master,
// IDLE/BUSY tracking of the current transfer and done/overflow interrupt.
module dmac_slave
    import dmac_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [7:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [31:0] desc_src,
    output logic [31:0] desc_dest,
    output logic [15:0] desc_size,
    input  logic        op_done,
    output logic        interrupt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] src_reg, dest_reg, dout_reg, rd_data;
    logic [15:0] size_reg;
    logic        int_en_reg;
    logic [1:0]  int_status_reg, int_status_next, int_clear;
    logic [0:0]  state_reg, state_next;
    logic        wr_en, rd_en, start_req, fifo_push, fifo_pop;
    logic        fifo_full, fifo_empty, empty_after, done_set, overflow_set;
    logic [CW-1:0] fifo_count;
    desc_t       push_desc, head_desc;

    assign wr_en     = s_sel & s_wr;
    assign rd_en     = s_sel & ~s_wr;
    assign start_req = wr_en & (s_addr == ADDR_START) & s_din[0];
    assign push_desc = '{src: src_reg, dest: dest_reg, size: size_reg};

    assign desc_valid = (state_reg == ST_IDLE) & ~fifo_empty;
    assign fifo_pop   = desc_valid & desc_ready;
    assign fifo_push  = start_req & (size_reg != 16'd0) & (~fifo_full | fifo_pop);
    assign overflow_set = start_req & fifo_full & ~fifo_pop;

    // Occupancy after this edge's pop/push decides whether op_done flags "all done".
    assign empty_after = ((fifo_count == CW'(0)) & ~fifo_push)
                       | ((fifo_count == CW'(1)) & fifo_pop & ~fifo_push);
    assign done_set  = op_done & empty_after;
    assign int_clear = (wr_en && s_addr == ADDR_INT_STATUS) ? s_din[1:0] : 2'b00;
    assign int_status_next = (int_status_reg & ~int_clear) | {overflow_set, done_set};

    assign desc_src  = head_desc.src;
    assign desc_dest = head_desc.dest;
    assign desc_size = head_desc.size;
    assign s_dout    = dout_reg;
    assign interrupt = int_en_reg & (|int_status_reg);

    dmac_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_desc),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head_desc)
    );

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_IDLE && fifo_pop)     state_next = ST_BUSY;
        else if (state_reg == ST_BUSY && op_done) state_next = ST_IDLE;
    end

    always_comb begin
        rd_data = 32'd0;
        case (s_addr)
            ADDR_INT_STATUS: rd_data = {30'd0, int_status_reg};
            ADDR_INT_ENABLE: rd_data = {31'd0, int_en_reg};
            ADDR_SRC:        rd_data = src_reg;
            ADDR_DEST:       rd_data = dest_reg;
            ADDR_SIZE:       rd_data = {16'd0, size_reg};
            ADDR_FIFO_COUNT: rd_data = 32'(fifo_count);
            ADDR_STATE:      rd_data = {31'd0, state_reg == ST_BUSY};
            default:         rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_reg        <= '0;
            dest_reg       <= '0;
            size_reg       <= '0;
            int_en_reg     <= 1'b0;
            int_status_reg <= '0;
            state_reg      <= ST_IDLE;
            dout_reg       <= '0;
        end else begin
            if (wr_en && s_addr == ADDR_SRC)        src_reg    <= s_din;
            if (wr_en && s_addr == ADDR_DEST)       dest_reg   <= s_din;
            if (wr_en && s_addr == ADDR_SIZE)       size_reg   <= s_din[15:0];
            if (wr_en && s_addr == ADDR_INT_ENABLE) int_en_reg <= s_din[0];
            int_status_reg <= int_status_next;
            state_reg      <= state_next;
            dout_reg       <= rd_en ? rd_data : 32'd0;
        end
    end

endmodule

// File: doc/dmac_slave.md
DMAC_SLAVE -- requirements
Module: dmac_slave

Interface
REQ-001 Parameters (name, default, meaning): FIFO_DEPTH, 4, descriptor FIFO entries (power of 2, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 s_sel  input  1  bus slave select; a bus access occurs on every cycle where it is high.
REQ-005 s_wr  input  1  1 = write, 0 = read; sampled with s_sel.
REQ-006 s_addr  input  8  word address; decoded values are in REQ-010.
REQ-007 s_din  input  32  write data; s_dout  output  32  registered read data.
REQ-008 desc_valid  output  1; desc_ready  input  1; desc_src, desc_dest  output  32; desc_size  output  16: descriptor hand-off to the DMAC master.
REQ-009 op_done  input  1  one-cycle pulse from master when the current descriptor finishes; interrupt  output  1  level interrupt.

Function
REQ-010 Register map: 0x00 START (write-only), 0x01 INT_STATUS (R/W), 0x02 INT_ENABLE (R/W, bit0), 0x03 SRC (R/W, 32b), 0x04 DEST (R/W, 32b), 0x05 SIZE (R/W, bits 15:0), 0x06 FIFO_COUNT (read-only), 0x07 STATE (read-only, bit0 = BUSY).
REQ-011 Reads of unmapped addresses and of START return 0; writes to them and to read-only registers have no effect.
REQ-012 Read latency is exactly 1: s_dout presents the addressed value in the cycle after s_sel=1, s_wr=0; otherwise it is 0.
REQ-013 A write to START with s_din[0]=1 pushes {SRC, DEST, SIZE} into the FIFO, using SRC/DEST/SIZE as they stood before that edge.
REQ-014 A START push is dropped if the FIFO is full or SIZE=0; a drop on full sets INT_STATUS bit1 (overflow).
REQ-015 INT_STATUS bit0 (done) sets on op_done when the FIFO is empty after that cycle's pop/push; a write to INT_STATUS with s_din[k]=1 clears bit k (write-1-to-clear).
REQ-016 If set and clear hit the same bit in the same cycle, set wins.
REQ-017 interrupt = INT_ENABLE[0] & (INT_STATUS[0] | INT_STATUS[1]); it is combinational from registered state.
REQ-018 FSM states: IDLE, BUSY. desc_valid = (state==IDLE) & FIFO not empty; desc_* show the FIFO head.
REQ-019 IDLE -> BUSY on desc_valid & desc_ready; that edge pops the head. BUSY -> IDLE on op_done.
REQ-020 op_done in IDLE is ignored, apart from the INT_STATUS rule in REQ-015.
REQ-021 Push and pop in the same cycle are both performed and the count is unchanged; with the FIFO full, that push is accepted.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; FIFO_COUNT ranges 0..FIFO_DEPTH.
REQ-023 desc_* stay stable while desc_valid=1 and desc_ready=0.

Reset
REQ-024 On reset high: all registers are 0, the FIFO is empty (pointers and count are 0), the state is IDLE, s_dout=0, desc_valid=0 and interrupt=0; this takes effect immediately and asynchronously, including in the middle of BUSY.
REQ-025 Release of reset requires no further cycles: the first clock edge after release performs normal operation.

Structure
REQ-026 The register address constants, the state encoding and the descriptor width (80 bits) are defined in the shared DMAC package.
REQ-027 The descriptor FIFO is a separate sub-module, dmac_desc_fifo (push, pop, full, empty, count, head data), with the same clk/reset.
REQ-028 Storage elements use the codebase's resettable flip-flop primitives, or equivalent asynchronous-reset always-blocks.

Verification
REQ-029 Write SRC=0x1000, DEST=0x2000, SIZE=0x10, then START=1 -> FIFO_COUNT reads 1 and desc_valid=1 with desc_src=0x1000, desc_dest=0x2000, desc_size=0x0010.
REQ-030 desc_ready=1 for one cycle, then op_done pulse with INT_ENABLE=1 -> state goes BUSY then IDLE, INT_STATUS=0x1 and interrupt=1; writing INT_STATUS=0x1 -> interrupt=0 on the next cycle.
REQ-031 Push 5 descriptors with FIFO_DEPTH=4 and desc_ready=0 -> FIFO_COUNT=4, INT_STATUS bit1=1, and the 5th descriptor is never presented.
REQ-032 FIFO full, START write in the same cycle as a pop -> the push is accepted and FIFO_COUNT stays 4; the wrap-around order of 6 descriptors is preserved.
REQ-033 Reset asserted in BUSY with 2 queued entries -> same cycle: desc_valid=0 and interrupt=0; after release, FIFO_COUNT=0 and STATE=0.
REQ-034 Read of 0x09 and of START -> s_dout=0 one cycle later; a write to FIFO_COUNT leaves it unchanged.
